// File: rtl/bus_guard.sv
// Single-outstanding bus stage: registers an arbiter request, forwards it as a one-cycle pulse,
// returns the peripheral response registered, and turns a hung peripheral into a bus error.
package bus_guard_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_error;
  } mem_out_type;

  localparam mem_in_type  init_mem_in  = '0;
  localparam mem_out_type init_mem_out = '0;

endpackage

module bus_guard
  import bus_guard_pkg::*;
#(
  parameter int unsigned timeout_cycles = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  up_in,
  output mem_out_type up_out,
  output mem_in_type  dn_in,
  input  mem_out_type dn_out,
  output logic        busy,
  output logic        tmo_pulse,
  output logic        proto_err
);

  localparam int CW = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  localparam bit TMO_EN = (timeout_cycles != 0);
  localparam logic [CW-1:0] TMO_LAST = CW'(timeout_cycles - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mem_in_type    dn_q, dn_d;
  mem_out_type   up_q, up_d;
  logic          busy_q, busy_d;
  logic          tmo_q, tmo_d;
  logic          perr_q, perr_d;

  // Next-state: pulses (dn valid, up ready, tmo) default low; data fields hold.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    dn_d             = dn_q;
    dn_d.mem_valid   = 1'b0;
    up_d             = up_q;
    up_d.mem_ready   = 1'b0;
    tmo_d            = 1'b0;
    perr_d           = perr_q;
    case (state_q)
      S_IDLE: begin
        if (up_in.mem_valid) begin
          dn_d           = up_in;
          dn_d.mem_valid = 1'b1;
          cnt_d          = '0;
          state_d        = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (up_in.mem_valid) begin
          perr_d = 1'b1;
        end else begin
          perr_d = perr_q;
        end
        // Ready beats a coincident timeout so a real response is never lost.
        if (dn_out.mem_ready) begin
          up_d.mem_ready = 1'b1;
          up_d.mem_rdata = dn_out.mem_rdata;
          up_d.mem_error = dn_out.mem_error;
          state_d        = S_IDLE;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          up_d.mem_ready = 1'b1;
          up_d.mem_rdata = 32'h0000_0000;
          up_d.mem_error = 1'b1;
          tmo_d          = 1'b1;
          state_d        = S_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_WAIT);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dn_q    <= init_mem_in;
      up_q    <= init_mem_out;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dn_q    <= dn_d;
      up_q    <= up_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      perr_q  <= perr_d;
    end
  end

  assign up_out    = up_q;
  assign dn_in     = dn_q;
  assign busy      = busy_q;
  assign tmo_pulse = tmo_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_bus_guard.sv
// Bench for bus_guard: directed scenarios plus random traffic against a transaction-level model.
module tb_bus_guard;
  import bus_guard_pkg::*;

  localparam int unsigned TMO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  mem_in_type  up_in, dn_in;
  mem_out_type up_out, dn_out;
  logic        busy, tmo_pulse, proto_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference state: whether an access is open, when it was accepted, and expected outputs.
  bit          m_busy, m_tmo, m_perr;
  int          m_start;
  mem_in_type  m_dn;
  mem_out_type m_up;

  bus_guard #(.timeout_cycles(TMO)) dut (
    .clock(clock), .reset(reset), .up_in(up_in), .up_out(up_out),
    .dn_in(dn_in), .dn_out(dn_out), .busy(busy), .tmo_pulse(tmo_pulse),
    .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_tmo = 1'b0; m_perr = 1'b0; m_start = 0;
    m_dn = '0; m_up = '0;
  endtask

  // Applies the rules of one clock edge using the inputs held across it.
  task automatic model_edge();
    m_dn.mem_valid = 1'b0;
    m_up.mem_ready = 1'b0;
    m_tmo = 1'b0;
    if (!m_busy) begin
      if (up_in.mem_valid) begin
        m_dn = up_in;
        m_busy = 1'b1;
        m_start = cyc;
      end
    end else begin
      if (up_in.mem_valid) m_perr = 1'b1;
      if (dn_out.mem_ready) begin
        m_up.mem_ready = 1'b1;
        m_up.mem_rdata = dn_out.mem_rdata;
        m_up.mem_error = dn_out.mem_error;
        m_busy = 1'b0;
      end else if (TMO != 0 && (cyc - m_start) == int'(TMO)) begin
        m_up.mem_ready = 1'b1;
        m_up.mem_rdata = 32'h0;
        m_up.mem_error = 1'b1;
        m_tmo = 1'b1;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic compare();
    chk("up_ready", 128'(up_out.mem_ready), 128'(m_up.mem_ready));
    if (m_up.mem_ready) begin
      chk("up_rdata", 128'(up_out.mem_rdata), 128'(m_up.mem_rdata));
      chk("up_error", 128'(up_out.mem_error), 128'(m_up.mem_error));
    end
    chk("dn_valid", 128'(dn_in.mem_valid), 128'(m_dn.mem_valid));
    if (m_busy) chk("dn_req", 128'(dn_in), 128'(m_dn));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("tmo_pulse", 128'(tmo_pulse), 128'(m_tmo));
    chk("proto_err", 128'(proto_err), 128'(m_perr));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
    compare();
  endtask

  task automatic cycle(input bit uv, input logic [31:0] ua, input bit dr,
                       input logic [31:0] dd, input bit de);
    up_in = '0;
    up_in.mem_valid = uv;
    up_in.mem_instr = ua[2];
    up_in.mem_addr  = ua;
    up_in.mem_wdata = ~ua;
    up_in.mem_wstrb = ua[3:0];
    dn_out.mem_ready = dr;
    dn_out.mem_rdata = dd;
    dn_out.mem_error = de;
    step();
  endtask

  task automatic read_case1(input string tag);
    cycle(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
    chk({tag, "_dnv"}, 128'(dn_in.mem_valid), 128'(1'b1));
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk({tag, "_busy4"}, 128'(busy), 128'(1'b1));
    cycle(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk({tag, "_rdy"}, 128'(up_out.mem_ready), 128'(1'b1));
    chk({tag, "_rdata"}, 128'(up_out.mem_rdata), 128'(32'hDEAD_BEEF));
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    up_in = '0;
    dn_out = '0;
    model_reset();
    #2;
    chk("rst_up", 128'(up_out), 128'(0));
    chk("rst_dn", 128'(dn_in), 128'(0));
    compare();
    #10 reset = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // 1: plain read
    read_case1("c1");

    // 2 and 6: timeout, then a late ready while idle, then a normal access
    cycle(1'b1, 32'h8000_0010, 1'b0, 32'h0, 1'b0);
    repeat (8) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("c2_tmo", 128'(tmo_pulse), 128'(1'b1));
    chk("c2_err", 128'(up_out.mem_error), 128'(1'b1));
    chk("c2_busy", 128'(busy), 128'(1'b0));
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'h0000_0BAD, 1'b1);
    chk("c6_noready", 128'(up_out.mem_ready), 128'(1'b0));
    cycle(1'b1, 32'h8000_0020, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
    chk("c6_rdata", 128'(up_out.mem_rdata), 128'(32'hCAFE_F00D));

    // 3: ready coincides with the last allowed wait cycle
    cycle(1'b1, 32'h8000_0030, 1'b0, 32'h0, 1'b0);
    repeat (7) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
    chk("c3_rdata", 128'(up_out.mem_rdata), 128'(32'h1234_5678));
    chk("c3_notmo", 128'(tmo_pulse), 128'(1'b0));
    chk("c3_err", 128'(up_out.mem_error), 128'(1'b0));

    // 4: second request while waiting is dropped and flagged
    cycle(1'b1, 32'h8000_0040, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h9000_0000, 1'b0, 32'h0, 1'b0);
    chk("c4_perr", 128'(proto_err), 128'(1'b1));
    chk("c4_nodnv", 128'(dn_in.mem_valid), 128'(1'b0));
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'h5555_AAAA, 1'b0);
    chk("c4_done", 128'(up_out.mem_ready), 128'(1'b1));

    // random traffic, including timeouts and back-to-back requests
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 5) == 0),
            $urandom, ($urandom_range(0, 3) == 0));
    end

    // 5: async reset in the middle of a wait, released between edges
    cycle(1'b1, 32'h8000_0050, 1'b0, 32'h0, 1'b0);
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("c5_busy", 128'(busy), 128'(1'b0));
    chk("c5_dn", 128'(dn_in), 128'(0));
    chk("c5_up", 128'(up_out), 128'(0));
    compare();
    #2 reset = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    read_case1("c5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
